// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pkg
// Description : Shared types and constants for the Mandelbrot escape-time
//               engine (7.20 fixed-point word, escape threshold, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

  // Signed 7.20 fixed-point word
  typedef logic signed [26:0] fix_t;

  // Escape threshold |z|^2 > 4.0, expressed in 7.20
  localparam fix_t FOUR = 27'sd4 <<< 20;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/signed_mult.sv
`default_nettype none
// ============================================================================
// Module      : signed_mult
// Description : Combinational signed 7.20 x 7.20 multiplier. The full product
//               is shifted right arithmetically by the fraction width, so the
//               result is truncated toward minus infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_mult #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 20
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;

  // Full-precision product, then drop fraction bits back into 7.20
  always_comb begin
    full = a * b;
    p    = WIDTH'(full >>> FRAC);
  end

endmodule
`default_nettype wire

// File: rtl/mandelbrot_iterator.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_iterator
// Description : Fixed-point escape-time engine. Iterates z <= z^2 + c once per
//               clock for a latched point c and reports the final iteration
//               count and whether |z|^2 exceeded 4.0, via start/done.
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_iterator
  import mandel_pkg::*;
#(
  parameter int WIDTH  = 27,
  parameter int ITER_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [WIDTH-1:0]  c_re,
  input  logic signed [WIDTH-1:0]  c_im,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     busy,
  output logic                     done,
  output logic        [ITER_W-1:0] iter_count,
  output logic                     escaped
);

  state_t state;
  state_t next_state;

  logic signed [WIDTH-1:0]  z_re;
  logic signed [WIDTH-1:0]  z_im;
  logic signed [WIDTH-1:0]  cr_q;
  logic signed [WIDTH-1:0]  ci_q;
  logic        [ITER_W-1:0] max_q;
  logic        [ITER_W-1:0] n;

  logic signed [WIDTH-1:0]  rr;
  logic signed [WIDTH-1:0]  ii;
  logic signed [WIDTH-1:0]  ri;
  logic signed [WIDTH:0]    rr_x;
  logic signed [WIDTH:0]    ii_x;
  logic signed [WIDTH:0]    mag;
  logic signed [WIDTH:0]    four_x;

  logic load;
  logic step;
  logic fin_esc;
  logic fin_lim;

  signed_mult #(.WIDTH(WIDTH)) u_mult_rr (.a(z_re), .b(z_re), .p(rr));
  signed_mult #(.WIDTH(WIDTH)) u_mult_ii (.a(z_im), .b(z_im), .p(ii));
  signed_mult #(.WIDTH(WIDTH)) u_mult_ri (.a(z_re), .b(z_im), .p(ri));

  // |z|^2 with one extra bit so the sum of two squares cannot wrap
  always_comb begin
    rr_x   = rr;
    ii_x   = ii;
    four_x = FOUR;
    mag    = rr_x + ii_x;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control strobes; escape test takes priority over the limit
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    fin_esc    = 1'b0;
    fin_lim    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ITER;
          load       = 1'b1;
        end
      end
      ITER: begin
        if (mag > four_x) begin
          fin_esc    = 1'b1;
          next_state = DONE;
        end else if (n == max_q) begin
          fin_lim    = 1'b1;
          next_state = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath registers: latch on start, iterate, capture result on finish
  always_ff @(posedge clk) begin
    if (reset) begin
      z_re       <= '0;
      z_im       <= '0;
      cr_q       <= '0;
      ci_q       <= '0;
      max_q      <= '0;
      n          <= '0;
      iter_count <= '0;
      escaped    <= 1'b0;
    end else begin
      if (load) begin
        cr_q  <= c_re;
        ci_q  <= c_im;
        max_q <= max_iter;
        z_re  <= '0;
        z_im  <= '0;
        n     <= '0;
      end
      if (step) begin
        z_re <= rr - ii + cr_q;
        z_im <= (ri <<< 1) + ci_q;
        n    <= n + 1'b1;
      end
      if (fin_esc || fin_lim) begin
        iter_count <= n;
        escaped    <= fin_esc;
      end
    end
  end

endmodule
`default_nettype wire
